// File: rtl/l1_ram_master_if.sv
// Command/response bundle between the layer sequencer (master) and l1_ram_master (slave).
interface l1_ram_master_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WORD_W = 48
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]   req_len;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_last;
  logic              err;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, err
  );
endinterface

// File: rtl/l1_ram_master.sv
// Layer-1 RAM master: single-word writes, burst reads, OE/WE never active together.
// Optional feature: define L1_RAM_MASTER_WRAP_EN to let read bursts wrap past DEPTH-1.
module l1_ram_master #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WORD_W = 48,
  parameter int unsigned DEPTH  = 88
) (
  input  logic              clk,
  input  logic              rst,
  l1_ram_master_if.slave    bus,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [WORD_W-1:0] ram_data,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic              ram_oe_n
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StTurn  = 2'd3;

  localparam logic [ADDR_W:0] DepthL = DEPTH[ADDR_W:0];
`ifdef L1_RAM_MASTER_WRAP_EN
  localparam int unsigned         LastInt  = DEPTH - 1;
  localparam logic [ADDR_W-1:0]   LastAddr = LastInt[ADDR_W-1:0];
`else
  localparam logic [ADDR_W+1:0]   DepthW   = DEPTH[ADDR_W+1:0];
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [WORD_W-1:0] wdata_q;
  logic [ADDR_W:0]   remaining_q;
  logic              rsp_valid_q, rsp_last_q, err_q;
  logic [WORD_W-1:0] rsp_data_q;

  logic              accept, legal, wr_ok, rd_ok, len_ok, capture, last_word;
  logic [ADDR_W+1:0] end_addr;

  assign bus.req_ready = (state_q == StIdle);
  assign accept        = bus.req_valid && bus.req_ready;

  // Extra headroom bit keeps addr + len from wrapping.
  assign end_addr = {2'b00, bus.req_addr} + {1'b0, bus.req_len};
  assign len_ok   = (bus.req_len != '0) && (bus.req_len <= DepthL);
  assign wr_ok    = ({1'b0, bus.req_addr} < DepthL);
`ifdef L1_RAM_MASTER_WRAP_EN
  assign rd_ok     = len_ok;
  assign addr_next = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
`else
  assign rd_ok     = len_ok && (end_addr <= DepthW);
  assign addr_next = addr_q + 1'b1;
`endif
  assign legal = bus.req_we ? wr_ok : rd_ok;

  // A word is taken only when the response slot is empty or being drained.
  assign capture   = (state_q == StRead) && (!rsp_valid_q || bus.rsp_ready);
  assign last_word = (remaining_q == {{ADDR_W{1'b0}}, 1'b1});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && legal) state_d = bus.req_we ? StWrite : StRead;
      StWrite: state_d = StTurn;
      StTurn:  state_d = StIdle;
      StRead:  if (capture && last_word) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      remaining_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if (state_q == StIdle && accept && legal) begin
        addr_q <= bus.req_addr;
        if (bus.req_we) wdata_q <= bus.req_wdata;
        else            remaining_q <= bus.req_len;
      end else if (capture) begin
        addr_q      <= addr_next;
        remaining_q <= remaining_q - 1'b1;
      end
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= ram_data;
        rsp_last_q  <= last_word;
      end else if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_last_q  <= 1'b0;
      end
    end
  end

  assign ram_addr = addr_q;
  assign ram_cs_n = !((state_q == StWrite) || (state_q == StRead));
  assign ram_we_n = (state_q != StWrite);
  assign ram_oe_n = (state_q != StRead);
  assign ram_data = (state_q == StWrite) ? wdata_q : {WORD_W{1'bz}};

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_l1_ram_master.sv
// Randomized bench for l1_ram_master with an in-bench memory/response-queue reference model.
module tb_l1_ram_master;
  localparam int ADDR_W = 7;
  localparam int WORD_W = 48;
  localparam int DEPTH  = 88;

  typedef struct {
    logic [WORD_W-1:0] d;
    bit                last;
  } exp_t;

  logic clk, rst;
  logic [ADDR_W-1:0] ram_addr;
  wire  [WORD_W-1:0] ram_data;
  logic ram_cs_n, ram_we_n, ram_oe_n;

  l1_ram_master_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  l1_ram_master #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_cs_n (ram_cs_n),
    .ram_we_n (ram_we_n),
    .ram_oe_n (ram_oe_n)
  );

  // RAM macro: asynchronous read while selected with OE low, write on the edge with WE low.
  logic [WORD_W-1:0] ram_mem [128];
  assign ram_data = (!ram_cs_n && !ram_oe_n) ? ram_mem[ram_addr] : {WORD_W{1'bz}};
  always @(posedge clk) if (!ram_cs_n && !ram_we_n) ram_mem[ram_addr] <= ram_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference model: memory contents and the words every accepted read must return.
  logic [WORD_W-1:0] model_mem [DEPTH];
  exp_t exp_q[$];

  function automatic bit model_legal(input bit we, input int addr, input int len);
    if (we) return addr < DEPTH;
`ifdef L1_RAM_MASTER_WRAP_EN
    return (len >= 1) && (len <= DEPTH);
`else
    return (len >= 1) && (addr + len <= DEPTH);
`endif
  endfunction

  int ready_mode = 0, pat_k = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: bus.rsp_ready = 1'b1;
      1: bus.rsp_ready = 1'($urandom_range(0, 1));
      default: begin
        bus.rsp_ready = (pat_k % 3 == 0);
        pat_k++;
      end
    endcase
  end

  bit mon_en = 0;
  bit p_rst = 1, p_acc = 0, p_legal = 0, p_we = 0, p_stall = 0;
  logic [ADDR_W-1:0] p_addr, p_ram_addr;
  logic [WORD_W-1:0] p_wdata;
  int hs_count = 0, first_hs = 0, last_hs = 0, n_last = 0, n_err = 0;
  logic [WORD_W-1:0] last_data;
  logic last_last;
  bit m_acc, m_legal;
  int m_addr, m_len;
  exp_t e;

  always @(negedge clk) if (mon_en) begin
    check(!(ram_we_n === 1'b0 && ram_oe_n === 1'b0), "we_oe_excl", {ram_we_n, ram_oe_n}, 2'b11);
    if (ram_we_n === 1'b1 && ram_oe_n === 1'b1)
      check(ram_data === {WORD_W{1'bz}}, "bus_released", ram_data, 0);
    if (p_rst) begin
      check(bus.rsp_valid === 1'b0, "rst_rsp_valid", bus.rsp_valid, 0);
      check({ram_cs_n, ram_we_n, ram_oe_n} === 3'b111, "rst_strobes",
            {ram_cs_n, ram_we_n, ram_oe_n}, 3'b111);
      check(bus.err === 1'b0 && ram_addr === '0 && bus.rsp_data === '0, "rst_regs",
            {bus.err, ram_addr}, 0);
    end else begin
      check(bus.err === (p_acc && !p_legal), "err_pulse", bus.err, p_acc && !p_legal);
      if (p_acc && p_legal && p_we) begin
        check({ram_cs_n, ram_we_n, ram_oe_n} === 3'b001, "write_strobes",
              {ram_cs_n, ram_we_n, ram_oe_n}, 3'b001);
        check(ram_addr === p_addr && ram_data === p_wdata, "write_addr_data", ram_data, p_wdata);
      end
      if (p_acc && p_legal && !p_we) begin
        check({ram_cs_n, ram_we_n, ram_oe_n} === 3'b010, "read_strobes",
              {ram_cs_n, ram_we_n, ram_oe_n}, 3'b010);
        check(ram_addr === p_addr, "read_addr", ram_addr, p_addr);
      end
      if (p_acc && !p_legal) check(ram_cs_n === 1'b1, "illegal_no_strobe", ram_cs_n, 1);
      if (p_stall)
        check(ram_addr === p_ram_addr && ram_oe_n === 1'b0, "stall_hold", ram_addr, p_ram_addr);
    end
    if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(0, "unexpected_rsp", bus.rsp_data, 0);
      end else begin
        e = exp_q.pop_front();
        check(bus.rsp_data === e.d, "rsp_data", bus.rsp_data, e.d);
        check(bus.rsp_last === e.last, "rsp_last", bus.rsp_last, e.last);
      end
      hs_count++;
      if (hs_count == 1) first_hs = cyc;
      last_hs   = cyc;
      last_data = bus.rsp_data;
      last_last = bus.rsp_last;
      if (bus.rsp_last === 1'b1) n_last++;
    end
    if (rst) exp_q.delete();
    if (bus.err === 1'b1) n_err++;
    m_acc   = !rst && bus.req_valid && bus.req_ready === 1'b1;
    m_addr  = int'(bus.req_addr);
    m_len   = int'(bus.req_len);
    m_legal = model_legal(bus.req_we, m_addr, m_len);
    if (m_acc && m_legal) begin
      if (bus.req_we) begin
        model_mem[m_addr] = bus.req_wdata;
      end else begin
        for (int i = 0; i < m_len; i++) begin
          e.d    = model_mem[(m_addr + i) % DEPTH];
          e.last = (i == m_len - 1);
          exp_q.push_back(e);
        end
      end
    end
    p_acc      = m_acc;
    p_legal    = m_legal;
    p_we       = bus.req_we;
    p_addr     = bus.req_addr;
    p_wdata    = bus.req_wdata;
    p_stall    = !rst && ram_oe_n === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b0;
    p_ram_addr = ram_addr;
    p_rst      = rst;
  end

  task automatic send(input bit we, input int addr, input int len, input logic [WORD_W-1:0] wd,
                      output int acc_cyc);
    bit done = 0;
    acc_cyc = -1;
    bus.req_we    = we;
    bus.req_addr  = addr[ADDR_W-1:0];
    bus.req_len   = len[ADDR_W:0];
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1 && !rst) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        done = 1;
      end
    end
    if (!done) begin
      check(0, "accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.rsp_valid === 1'b0 && bus.req_ready === 1'b1) done = 1;
    end
    if (!done) check(0, "idle_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    hs_count = 0;
    n_last   = 0;
  endtask

  int c1, c2, k, e0, addr, len;
  bit we;
  logic [63:0] rnd;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload addr i = i.
    for (int i = 0; i < DEPTH; i++) send(1'b1, i, 0, WORD_W'(i), c1);
    bus.req_valid = 1'b0;
    wait_idle();

    // Full burst, one word per cycle.
    ready_mode = 0;
    clr_stats();
    send(1'b0, 0, DEPTH, '0, c1);
    bus.req_valid = 1'b0;
    wait_idle();
    check(hs_count == DEPTH, "burst_count", hs_count, DEPTH);
    check(last_hs - first_hs == DEPTH - 1, "burst_span", last_hs - first_hs, DEPTH - 1);
    check(n_last == 1 && last_last === 1'b1, "burst_last_once", n_last, 1);
    check(last_data === 48'd87, "burst_last_word", last_data, 87);

    // Write then read back.
    send(1'b1, 5, 0, 48'hABCD_0123_4567, c1);
    send(1'b0, 5, 1, '0, c2);
    bus.req_valid = 1'b0;
    wait_idle();
    check(last_data === 48'hABCD_0123_4567, "readback_data", last_data, 48'hABCD_0123_4567);
    check(last_last === 1'b1, "readback_last", last_last, 1);

    // Backpressure 1,0,0,1,...
    ready_mode = 2;
    pat_k = 0;
    clr_stats();
    send(1'b0, 10, 4, '0, c1);
    bus.req_valid = 1'b0;
    wait_idle();
    check(hs_count == 4 && last_data === 48'd13, "bp_words", last_data, 13);
    ready_mode = 0;

    // Illegal commands.
    e0 = n_err;
    clr_stats();
    send(1'b0, 85, 4, '0, c1);
    bus.req_valid = 1'b0;
    wait_idle();
    send(1'b0, 0, 0, '0, c1);
    bus.req_valid = 1'b0;
    wait_idle();
    send(1'b1, 88, 0, 48'hDEAD, c1);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef L1_RAM_MASTER_WRAP_EN
    check(n_err - e0 == 2, "illegal_err_count", n_err - e0, 2);
    check(hs_count == 4 && last_data === 48'd0, "wrap_words", last_data, 0);
`else
    check(n_err - e0 == 3, "illegal_err_count", n_err - e0, 3);
    check(hs_count == 0, "illegal_no_rsp", hs_count, 0);
`endif

    // Back-to-back write then read.
    send(1'b1, 30, 0, 48'h30, c1);
    send(1'b0, 30, 1, '0, c2);
    bus.req_valid = 1'b0;
    check(c2 - c1 == 3, "wr_rd_spacing", c2 - c1, 3);
    wait_idle();

    // Random traffic.
    ready_mode = 1;
    for (int n = 0; n < 250; n++) begin
      if (n == 125) ready_mode = 2;
      we = ($urandom_range(0, 2) == 0);
      rnd = {$urandom, $urandom};
      if (we) begin
        addr = $urandom_range(0, 95);
        len  = $urandom_range(0, 255);
      end else begin
        addr = $urandom_range(0, DEPTH - 1);
        k = $urandom_range(0, 9);
        len = (k == 0) ? 0 : (k == 1) ? $urandom_range(80, 89) : $urandom_range(1, 8);
      end
      send(we, addr, len, rnd[WORD_W-1:0], c1);
      if ($urandom_range(0, 1) == 1) begin
        bus.req_valid = 1'b0;
        k = $urandom_range(0, 3);
        if (k > 0) begin
          repeat (k) @(posedge clk);
          #1;
        end
      end
    end
    bus.req_valid = 1'b0;
    ready_mode = 1;
    wait_idle();

    // Reset mid-burst.
    ready_mode = 0;
    clr_stats();
    send(1'b0, 0, 10, '0, c1);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 100 && hs_count < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check(hs_count >= 3, "midburst_progress", hs_count, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b1, 20, 0, 48'h1234_5678_9ABC, c1);
    check(c1 > 0, "post_rst_write_accept", c1, 1);
    send(1'b0, 20, 1, '0, c2);
    bus.req_valid = 1'b0;
    wait_idle();
    check(last_data === 48'h1234_5678_9ABC, "post_rst_readback", last_data, 48'h1234_5678_9ABC);

    repeat (3) @(posedge clk);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
